// File: rtl/router_pkg.sv
// Shared constants and helpers for the 1x3 router channel logic.
package router_pkg;

    localparam int unsigned NUM_CH      = 3;
    localparam int unsigned ADDR_W      = 2;
    localparam int unsigned TIMEOUT_DEF = 30;
    localparam int unsigned CNT_W_DEF   = 5;

    // Header address field; ADDR_NONE routes the packet nowhere.
    typedef enum logic [ADDR_W-1:0] {
        ADDR_CH0  = 2'b00,
        ADDR_CH1  = 2'b01,
        ADDR_CH2  = 2'b10,
        ADDR_NONE = 2'b11
    } chan_addr_e;

    // One-hot channel select for a latched address; ADDR_NONE selects nothing.
    function automatic logic [NUM_CH-1:0] addr_to_onehot(input chan_addr_e addr);
        logic [NUM_CH-1:0] sel;
        sel = '0;
        case (addr)
            ADDR_CH0: sel = 3'b001;
            ADDR_CH1: sel = 3'b010;
            ADDR_CH2: sel = 3'b100;
            default:  sel = 3'b000;
        endcase
        return sel;
    endfunction

endpackage : router_pkg

// File: rtl/router_timeout_ctr.sv
// Per-channel idle timeout: pulses soft_reset for one cycle after TIMEOUT
// consecutive cycles in which the channel holds data that nobody reads.
module router_timeout_ctr #(
    parameter int unsigned TIMEOUT = 30,
    parameter int unsigned CNT_W   = 5
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld,
    input  logic read_enb,
    output logic soft_reset
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             soft_q;
    logic             soft_d;
    logic             idle;

    assign idle = vld & ~read_enb;

    // Next-state: a pulse or any non-idle cycle restarts the count; the
    // terminal count wraps to zero while raising the pulse.
    always_comb begin
        cnt_d  = '0;
        soft_d = 1'b0;
        if (soft_q) begin
            cnt_d = '0;
        end else if (!idle) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            cnt_d  = '0;
            soft_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State register with synchronous reset cancelling any pending pulse.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_q  <= '0;
            soft_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            soft_q <= soft_d;
        end
    end

    assign soft_reset = soft_q;

endmodule : router_timeout_ctr

// File: rtl/router_chan_ctrl.sv
// Channel controller between the router input FSM and the three output FIFOs:
// latches the header address, steers the write strobe, returns the selected
// FIFO's full flag, and runs one idle timeout per channel.
module router_chan_ctrl
    import router_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        detect_add,
    input  logic [1:0]  data_in,
    input  logic        write_enb_reg,
    input  logic        empty_0,
    input  logic        empty_1,
    input  logic        empty_2,
    input  logic        full_0,
    input  logic        full_1,
    input  logic        full_2,
    input  logic        read_enb_0,
    input  logic        read_enb_1,
    input  logic        read_enb_2,
    output logic [2:0]  write_enb,
    output logic        fifo_full,
    output logic        vld_out_0,
    output logic        vld_out_1,
    output logic        vld_out_2,
    output logic        soft_reset_0,
    output logic        soft_reset_1,
    output logic        soft_reset_2
);

    chan_addr_e        addr_q;
    chan_addr_e        addr_d;
    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] empty_v;
    logic [NUM_CH-1:0] full_v;
    logic [NUM_CH-1:0] rd_v;
    logic [NUM_CH-1:0] vld_v;
    logic [NUM_CH-1:0] srst_v;

    assign empty_v = {empty_2, empty_1, empty_0};
    assign full_v  = {full_2, full_1, full_0};
    assign rd_v    = {read_enb_2, read_enb_1, read_enb_0};

    // Address capture while the FSM decodes the header; held otherwise.
    always_comb begin
        addr_d = addr_q;
        if (detect_add) begin
            addr_d = chan_addr_e'(data_in);
        end
    end

    // Address register; an unrouted address is the safe reset value.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            addr_q <= ADDR_NONE;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign sel = addr_to_onehot(addr_q);

    // Write steering and full-flag return use the previously latched address,
    // so a header cycle that also writes still targets the old channel.
    always_comb begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
        if (write_enb_reg) begin
            write_enb = sel;
        end
        fifo_full = |(sel & full_v);
    end

    assign vld_v = ~empty_v;

    // One independent timeout per channel.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_tmo
        router_timeout_ctr #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_tmo (
            .clock      (clock),
            .resetn     (resetn),
            .vld        (vld_v[g]),
            .read_enb   (rd_v[g]),
            .soft_reset (srst_v[g])
        );
    end

    assign vld_out_0    = vld_v[0];
    assign vld_out_1    = vld_v[1];
    assign vld_out_2    = vld_v[2];
    assign soft_reset_0 = srst_v[0];
    assign soft_reset_1 = srst_v[1];
    assign soft_reset_2 = srst_v[2];

endmodule : router_chan_ctrl

// File: tb/tb_router_chan_ctrl.sv
// Directed bench for router_chan_ctrl: a vector table for the address latch,
// steering and full mux, plus cycle-walk sequences for the timeouts.
module tb_router_chan_ctrl;

    logic       clock;
    logic       resetn;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic       empty_0, empty_1, empty_2;
    logic       full_0, full_1, full_2;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    int checks;
    int errors;

    router_chan_ctrl #(.TIMEOUT(30), .CNT_W(5)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .detect_add    (detect_add),
        .data_in       (data_in),
        .write_enb_reg (write_enb_reg),
        .empty_0       (empty_0),
        .empty_1       (empty_1),
        .empty_2       (empty_2),
        .full_0        (full_0),
        .full_1        (full_1),
        .full_2        (full_2),
        .read_enb_0    (read_enb_0),
        .read_enb_1    (read_enb_1),
        .read_enb_2    (read_enb_2),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .vld_out_0     (vld_out_0),
        .vld_out_1     (vld_out_1),
        .vld_out_2     (vld_out_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       det;
        logic [1:0] data;
        logic       wer;
        logic [2:0] full;   // {full_2, full_1, full_0}
        logic [2:0] empty;  // {empty_2, empty_1, empty_0}
        logic [2:0] exp_we;
        logic       exp_ff;
        logic [2:0] exp_vld;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [2:0] srst();
        return {soft_reset_2, soft_reset_1, soft_reset_0};
    endfunction

    initial begin
        checks        = 0;
        errors        = 0;
        resetn        = 1'b0;
        detect_add    = 1'b0;
        data_in       = 2'b00;
        write_enb_reg = 1'b1;
        {empty_2, empty_1, empty_0}          = 3'b111;
        {full_2, full_1, full_0}             = 3'b000;
        {read_enb_2, read_enb_1, read_enb_0} = 3'b000;

        //          det  data   wer  full    empty   we      ff    vld
        vecs[0]  = '{1'b1, 2'b01, 1'b0, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 3'b010, 3'b111, 3'b010, 1'b1, 3'b000};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 3'b101, 3'b111, 3'b010, 1'b0, 3'b000};
        vecs[3]  = '{1'b0, 2'b00, 1'b1, 3'b111, 3'b111, 3'b010, 1'b1, 3'b000};
        vecs[4]  = '{1'b1, 2'b11, 1'b1, 3'b111, 3'b111, 3'b010, 1'b1, 3'b000};
        vecs[5]  = '{1'b0, 2'b00, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000};
        vecs[6]  = '{1'b1, 2'b00, 1'b0, 3'b001, 3'b110, 3'b000, 1'b0, 3'b001};
        vecs[7]  = '{1'b0, 2'b00, 1'b1, 3'b001, 3'b010, 3'b001, 1'b1, 3'b101};
        vecs[8]  = '{1'b1, 2'b10, 1'b1, 3'b100, 3'b111, 3'b001, 1'b0, 3'b000};
        vecs[9]  = '{1'b0, 2'b00, 1'b1, 3'b100, 3'b011, 3'b100, 1'b1, 3'b100};
        vecs[10] = '{1'b0, 2'b00, 1'b0, 3'b000, 3'b101, 3'b000, 1'b0, 3'b010};

        // Reset held for two edges with a write request pending.
        for (int r = 0; r < 2; r++) begin
            tick();
            check($sformatf("rst%0d_we", r), 8'(write_enb), 8'h0);
            check($sformatf("rst%0d_ff", r), 8'(fifo_full), 8'h0);
            check($sformatf("rst%0d_srst", r), 8'(srst()), 8'h0);
            check($sformatf("rst%0d_vld", r), 8'({vld_out_2, vld_out_1, vld_out_0}), 8'h0);
        end
        resetn        = 1'b1;
        write_enb_reg = 1'b0;

        // Address latch, steering and full mux.
        for (int i = 0; i < 11; i++) begin
            detect_add    = vecs[i].det;
            data_in       = vecs[i].data;
            write_enb_reg = vecs[i].wer;
            {full_2, full_1, full_0}    = vecs[i].full;
            {empty_2, empty_1, empty_0} = vecs[i].empty;
            #1;
            check($sformatf("vec%0d_we", i), 8'(write_enb), 8'(vecs[i].exp_we));
            check($sformatf("vec%0d_ff", i), 8'(fifo_full), 8'(vecs[i].exp_ff));
            check($sformatf("vec%0d_vld", i), 8'({vld_out_2, vld_out_1, vld_out_0}), 8'(vecs[i].exp_vld));
            tick();
        end
        detect_add    = 1'b0;
        write_enb_reg = 1'b0;
        {full_2, full_1, full_0}    = 3'b000;
        {empty_2, empty_1, empty_0} = 3'b111;
        tick();
        tick();

        // Channel 0 unread: pulses visible in idle cycles 31 and 62 only.
        empty_0 = 1'b0;
        for (int k = 1; k <= 62; k++) begin
            #1;
            check($sformatf("t4_srst_c%0d", k), 8'(srst()),
                  8'((k == 31 || k == 62) ? 3'b001 : 3'b000));
            tick();
        end
        empty_0 = 1'b1;
        tick();
        tick();

        // One read at idle cycle 29 restarts the count: pulse lands at 60.
        empty_0 = 1'b0;
        for (int k = 1; k <= 62; k++) begin
            read_enb_0 = (k == 29);
            #1;
            check($sformatf("t5_srst_c%0d", k), 8'(srst()),
                  8'((k == 60) ? 3'b001 : 3'b000));
            tick();
        end
        read_enb_0 = 1'b0;
        empty_0    = 1'b1;
        tick();
        tick();

        // Channel 2 with a one-cycle reset at idle cycle 20: pulse at 51.
        empty_2 = 1'b0;
        for (int k = 1; k <= 55; k++) begin
            resetn = (k != 20);
            #1;
            check($sformatf("t6_srst_c%0d", k), 8'(srst()),
                  8'((k == 51) ? 3'b100 : 3'b000));
            tick();
        end
        resetn  = 1'b1;
        empty_2 = 1'b1;
        tick();
        tick();

        // Channels 0 and 1 idle together: simultaneous pulses at cycle 31.
        empty_0 = 1'b0;
        empty_1 = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            #1;
            check($sformatf("mc_srst_c%0d", k), 8'(srst()),
                  8'((k == 31) ? 3'b011 : 3'b000));
            tick();
        end
        empty_0 = 1'b1;
        empty_1 = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_router_chan_ctrl

// File: doc/router_chan_ctrl.md
Name: router_chan_ctrl

Overview:
Channel controller between the router input FSM and the three output FIFOs of the 1x3 router.
- Latches the destination address from the header byte.
- Steers the FSM's write strobe to the selected FIFO and returns that FIFO's full flag to the FSM.
- Drives per-channel valid-out flags.
- Runs one idle-timeout per channel; when a destination does not read its pending packet in time, it pulses that channel's soft reset (consumed by the FSM and the FIFOs).

Parameters:
TIMEOUT, 30, consecutive unread cycles (vld_out_i=1, read_enb_i=0) before soft_reset_i fires; legal range 2..31.
CNT_W, 5, timeout counter width; must satisfy 2**CNT_W > TIMEOUT.

Ports:
clock  in  1  system clock, all state updates on rising edge
resetn  in  1  synchronous active-low reset
detect_add  in  1  FSM in address-decode state; latch data_in this cycle
data_in  in  2  header address field: 00/01/10 = channel 0/1/2, 11 = no channel
write_enb_reg  in  1  FSM write request for the current packet
empty_0, empty_1, empty_2  in  1 each  FIFO empty flags
full_0, full_1, full_2  in  1 each  FIFO full flags
read_enb_0, read_enb_1, read_enb_2  in  1 each  destination read strobes
write_enb  out  3  one-hot FIFO write enable, bit i = FIFO i
fifo_full  out  1  full flag of the selected FIFO
vld_out_0, vld_out_1, vld_out_2  out  1 each  channel has data
soft_reset_0, soft_reset_1, soft_reset_2  out  1 each  one-cycle timeout reset per channel

Behaviour:
- Reset (resetn=0 at a rising edge):
  - addr_q <= 2'b11.
  - All timeout counters <= 0.
  - All soft_reset_i <= 0.
  - Resulting outputs: write_enb=000, fifo_full=0; vld_out_i follow ~empty_i.
- Address latch:
  - addr_q <= data_in at any edge where detect_add=1; otherwise addr_q is held.
  - Latency 1: the strobe uses the address latched at an earlier edge. When detect_add and write_enb_reg are both 1 in the same cycle, write_enb uses the previous addr_q.
- write_enb (combinational):
  - write_enb_reg=0 -> 000.
  - write_enb_reg=1 -> addr_q 00->001, 01->010, 10->100, 11->000.
- fifo_full (combinational): addr_q 00/01/10 selects full_0/full_1/full_2; 11 -> 0.
- vld_out_i (combinational) = ~empty_i, independent of addr_q.
- Timeout, one identical instance per channel i:
  - idle_i = vld_out_i & ~read_enb_i.
  - cnt_i update at each edge:
    - soft_reset_i=1: cnt_i <= 0.
    - Else idle_i=0: cnt_i <= 0.
    - Else idle_i=1 and cnt_i == TIMEOUT-1: cnt_i <= 0 and soft_reset_i <= 1.
    - Else idle_i=1: cnt_i <= cnt_i + 1.
  - soft_reset_i <= 0 at every edge that does not set it.
  - Result: soft_reset_i is high for exactly one cycle. It rises at the edge that samples the TIMEOUT-th consecutive idle cycle, i.e. it is visible in idle cycle TIMEOUT+1.
  - Any single cycle with read_enb_i=1 or empty_i=1 restarts the count from zero.
  - Counters never wrap; cnt_i never exceeds TIMEOUT-1.
  - Channels are fully independent; several soft_reset_i may be high in the same cycle.
- Mid-operation reset: resetn=0 clears counters and cancels any pending soft reset. After resetn returns to 1, a full TIMEOUT idle cycles are required before soft_reset_i fires.
- The block never gates write_enb on full_i. The FSM uses fifo_full to stop writing.

Decomposition:
- Shared package router_pkg holds:
  - Address constants: ADDR_CH0=2'b00, ADDR_CH1=2'b01, ADDR_CH2=2'b10, ADDR_NONE=2'b11.
  - NUM_CH=3.
  - Default TIMEOUT=30.
- Sub-module router_timeout_ctr:
  - Parameters TIMEOUT, CNT_W.
  - Ports clock, resetn, vld, read_enb, soft_reset.
  - Instantiated three times.
- Address latch, one-hot decode and full mux stay in the top module.

Test Plan:
1. Hold resetn=0 for 2 cycles with empty_i=1, write_enb_reg=1 -> write_enb=000, fifo_full=0, all soft_reset_i=0, vld_out_i=0.
2. detect_add=1, data_in=01 for one cycle, then write_enb_reg=1 and full_1=1 -> write_enb=010, fifo_full=1; full_0/full_2 toggling has no effect.
3. detect_add=1, data_in=11, then write_enb_reg=1 with all full_i=1 -> write_enb=000, fifo_full=0.
4. empty_0=0, read_enb_0=0 held -> soft_reset_0=1 only in idle cycle 31, 0 in cycle 32; soft_reset_1/2 stay 0. With the FIFO still non-empty, the next pulse comes in idle cycle 62.
5. Same as 4, but read_enb_0=1 for one cycle at idle cycle 29 -> no pulse at cycle 31; the next pulse comes 30 idle cycles after the read.
6. Channel 2 idle; resetn=0 for one cycle at idle cycle 20 -> no soft_reset_2 at cycle 31; the pulse appears 31 cycles after resetn returns high.
